// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, state encoding and address-field helpers for the cache controller
package cache_pkg;

    localparam int WORD     = 32;
    localparam int ADDRESSL = 15;
    localparam int LINES    = 1024;
    localparam int INDEXL   = $clog2(LINES);
    localparam int TAGL     = ADDRESSL - INDEXL - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cacheStateT;

    // Field extractors for the default address geometry.
    function automatic logic [TAGL-1:0] getTag(input logic [ADDRESSL-1:0] addr);
        return addr[ADDRESSL-1:INDEXL+2];
    endfunction

    function automatic logic [INDEXL-1:0] getIndex(input logic [ADDRESSL-1:0] addr);
        return addr[INDEXL+1:2];
    endfunction

    function automatic logic [1:0] getOffset(input logic [ADDRESSL-1:0] addr);
        return addr[1:0];
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - direct-mapped valid/tag/data storage with combinational lookup, line fill and word write
module cache_line_array
    import cache_pkg::*;
#(
    parameter int WORD_W  = cache_pkg::WORD,
    parameter int INDEX_W = cache_pkg::INDEXL,
    parameter int TAG_W   = cache_pkg::TAGL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INDEX_W-1:0]       lookupIndex,
    input  logic [TAG_W-1:0]         lookupTag,
    input  logic [1:0]               lookupOffset,
    output logic                     lookupHit,
    output logic [WORD_W-1:0]        lookupWord,
    input  logic                     fillEn,
    input  logic [INDEX_W-1:0]       fillIndex,
    input  logic [TAG_W-1:0]         fillTag,
    input  logic [3:0][WORD_W-1:0]   fillData,
    input  logic                     wordEn,
    input  logic [INDEX_W-1:0]       wordIndex,
    input  logic [1:0]               wordOffset,
    input  logic [WORD_W-1:0]        wordData
);

    localparam int NLINES = 1 << INDEX_W;

    logic [NLINES-1:0]       validBits;
    logic [TAG_W-1:0]        tagMem  [NLINES];
    logic [3:0][WORD_W-1:0]  dataMem [NLINES];

    // Valid bits are the only state that must be clean after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validBits <= '0;
        end else if (fillEn) begin
            validBits[fillIndex] <= 1'b1;
        end
    end

    // Tag/data storage: a fill replaces the whole line, a write-hit patches one word.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagMem[fillIndex]  <= fillTag;
            dataMem[fillIndex] <= fillData;
        end else if (wordEn) begin
            dataMem[wordIndex][wordOffset] <= wordData;
        end
    end

    assign lookupHit  = validBits[lookupIndex] && (tagMem[lookupIndex] == lookupTag);
    assign lookupWord = dataMem[lookupIndex][lookupOffset];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through cache controller; CACHE_STATS_EN adds load hit/miss counters
module cache_controller
    import cache_pkg::*;
#(
    parameter int WORD        = cache_pkg::WORD,
    parameter int ADDRESSL    = cache_pkg::ADDRESSL,
    parameter int LINES       = cache_pkg::LINES,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDRESSL-1:0] req_addr,
    input  logic [WORD-1:0]     req_wdata,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [WORD-1:0]     resp_rdata,
    output logic                resp_hit,
    output logic [ADDRESSL-1:0] mem_address,
    output logic [ADDRESSL-1:0] mem_address0,
    output logic [ADDRESSL-1:0] mem_address1,
    output logic [ADDRESSL-1:0] mem_address2,
    output logic [ADDRESSL-1:0] mem_address3,
    output logic                mem_read,
    output logic                mem_write,
    output logic [WORD-1:0]     mem_write_data,
    input  logic [WORD-1:0]     mem_block0,
    input  logic [WORD-1:0]     mem_block1,
    input  logic [WORD-1:0]     mem_block2,
    input  logic [WORD-1:0]     mem_block3
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int TAG_BITS   = ADDRESSL - INDEX_BITS - 2;
    localparam int CNTW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    cacheStateT           state, nextState;
    logic [ADDRESSL-1:0]  latchedAddr;
    logic [WORD-1:0]      latchedData;
    logic                 latchedHit;
    logic [CNTW-1:0]      fillCount;
    logic                 accept, fillDone, wordEn;
    logic                 lookupHit;
    logic [WORD-1:0]      lookupWord;
    logic [3:0][WORD-1:0] blockData;
    logic [ADDRESSL-3:0]  lineAddr;

    assign blockData = {mem_block3, mem_block2, mem_block1, mem_block0};
    assign lineAddr  = latchedAddr[ADDRESSL-1:2];
    assign wordEn    = (state == WRITE) && latchedHit;

    cache_line_array #(
        .WORD_W  (WORD),
        .INDEX_W (INDEX_BITS),
        .TAG_W   (TAG_BITS)
    ) u_lines (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookupIndex  (req_addr[INDEX_BITS+1:2]),
        .lookupTag    (req_addr[ADDRESSL-1:INDEX_BITS+2]),
        .lookupOffset (req_addr[1:0]),
        .lookupHit    (lookupHit),
        .lookupWord   (lookupWord),
        .fillEn       (fillDone),
        .fillIndex    (latchedAddr[INDEX_BITS+1:2]),
        .fillTag      (latchedAddr[ADDRESSL-1:INDEX_BITS+2]),
        .fillData     (blockData),
        .wordEn       (wordEn),
        .wordIndex    (latchedAddr[INDEX_BITS+1:2]),
        .wordOffset   (latchedAddr[1:0]),
        .wordData     (latchedData)
    );

    // State register; reset abandons any fill or write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and memory-side outputs; address buses stay 0 unless their phase is active.
    always_comb begin
        nextState      = state;
        accept         = 1'b0;
        fillDone       = 1'b0;
        req_ready      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_address0   = '0;
        mem_address1   = '0;
        mem_address2   = '0;
        mem_address3   = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                req_ready = rst_n;
                accept    = req_valid && rst_n;
                if (accept) begin
                    if (req_write) begin
                        nextState = WRITE;
                    end else if (!lookupHit) begin
                        nextState = FILL;
                    end
                end
            end
            FILL: begin
                mem_read     = 1'b1;
                mem_address0 = {lineAddr, 2'b00};
                mem_address1 = {lineAddr, 2'b01};
                mem_address2 = {lineAddr, 2'b10};
                mem_address3 = {lineAddr, 2'b11};
                if (fillCount == CNTW'(MEM_LATENCY - 1)) begin
                    fillDone  = 1'b1;
                    nextState = IDLE;
                end
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = latchedAddr;
                mem_write_data = latchedData;
                nextState      = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Request latches, fill latency counter and the registered one-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latchedAddr <= '0;
            latchedData <= '0;
            latchedHit  <= 1'b0;
            fillCount   <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_rdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            if (accept) begin
                latchedAddr <= req_addr;
                latchedData <= req_wdata;
                latchedHit  <= lookupHit;
                fillCount   <= '0;
                if (!req_write && lookupHit) begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b1;
                    resp_rdata <= lookupWord;
                end
            end
            if (state == FILL && !fillDone) begin
                fillCount <= fillCount + 1'b1;
            end
            if (fillDone) begin
                resp_valid <= 1'b1;
                resp_rdata <= blockData[latchedAddr[1:0]];
            end
            if (state == WRITE) begin
                resp_valid <= 1'b1;
                resp_hit   <= latchedHit;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic loadHit;
    assign loadHit = accept && !req_write && lookupHit;

    // Saturating load counters, updated on the edge that raises resp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (loadHit && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fillDone && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed table-driven bench for cache_controller
module tb_cache_controller;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_hit, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_write_data;
    logic [14:0] mem_address, mem_address0, mem_address1, mem_address2, mem_address3;
    wire  [31:0] memBlock0, memBlock1, memBlock2, memBlock3;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_controller #(.MEM_LATENCY(MEM_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_hit       (resp_hit),
        .mem_address    (mem_address),
        .mem_address0   (mem_address0),
        .mem_address1   (mem_address1),
        .mem_address2   (mem_address2),
        .mem_address3   (mem_address3),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_block0     (memBlock0),
        .mem_block1     (memBlock1),
        .mem_block2     (memBlock2),
        .mem_block3     (memBlock3)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    // Data memory model: preset contents unless overwritten by a DUT store.
    logic [31:0] memData    [0:32767];
    bit          memWritten [0:32767];

    function automatic logic [31:0] initVal(input logic [14:0] a);
        if (a >= 15'h0004 && a <= 15'h0007) return 32'd10 + 32'(a - 15'h0004);
        if (a >= 15'h1004 && a <= 15'h1007) return 32'd20 + 32'(a - 15'h1004);
        return 32'h1000_0000 + 32'(a);
    endfunction

    function automatic logic [31:0] memWord(input logic [14:0] a);
        return memWritten[a] ? memData[a] : initVal(a);
    endfunction

    always @(posedge clk) begin
        if (mem_write) begin
            memData[mem_address]    <= mem_write_data;
            memWritten[mem_address] <= 1'b1;
        end
    end

    assign memBlock0 = mem_read ? memWord(mem_address0) : 32'bz;
    assign memBlock1 = mem_read ? memWord(mem_address1) : 32'bz;
    assign memBlock2 = mem_read ? memWord(mem_address2) : 32'bz;
    assign memBlock3 = mem_read ? memWord(mem_address3) : 32'bz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request at a negedge with the DUT idle; returns at the negedge showing the response.
    task automatic doReq(input logic wr, input logic [14:0] addr, input logic [31:0] wd,
                         output logic gotHit, output logic [31:0] gotData,
                         output int rdCyc, output int wrCyc, output logic busOk, output logic done);
        rdCyc = 0; wrCyc = 0; busOk = 1'b1; done = 1'b0; gotHit = 1'b0; gotData = '0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (resp_valid) begin
                done = 1'b1; gotHit = resp_hit; gotData = resp_rdata;
            end else begin
                if (mem_read && mem_write) busOk = 1'b0;
                if (mem_read) begin
                    rdCyc++;
                    if (mem_address0 != {addr[14:2], 2'b00} || mem_address1 != {addr[14:2], 2'b01} ||
                        mem_address2 != {addr[14:2], 2'b10} || mem_address3 != {addr[14:2], 2'b11})
                        busOk = 1'b0;
                end
                if (mem_write) begin
                    wrCyc++;
                    if (mem_address != addr || mem_write_data != wd) busOk = 1'b0;
                end
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [31:0] wdata;
        logic        expHit;
        logic [31:0] expData;
    } vecT;

    vecT vecs [12];

    initial begin
        logic        h, ok, dn;
        logic [31:0] d;
        int          rc, wc;
        int          expHits, expMisses;

        vecs[0]  = '{1'b0, 15'h0005, 32'h0,    1'b0, 32'd11};
        vecs[1]  = '{1'b0, 15'h0006, 32'h0,    1'b1, 32'd12};
        vecs[2]  = '{1'b0, 15'h1005, 32'h0,    1'b0, 32'd21};
        vecs[3]  = '{1'b0, 15'h0005, 32'h0,    1'b0, 32'd11};
        vecs[4]  = '{1'b1, 15'h0005, 32'hDEAD, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 15'h0005, 32'h0,    1'b1, 32'hDEAD};
        vecs[6]  = '{1'b1, 15'h0100, 32'hBEEF, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 15'h0100, 32'h0,    1'b0, 32'hBEEF};
        vecs[8]  = '{1'b0, 15'h0103, 32'h0,    1'b1, 32'h1000_0103};
        vecs[9]  = '{1'b0, 15'h1006, 32'h0,    1'b0, 32'd22};
        vecs[10] = '{1'b1, 15'h1006, 32'h1234, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 15'h1006, 32'h0,    1'b1, 32'h1234};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset mem_read", 32'(mem_read), 32'd0);
        check("reset mem_write", 32'(mem_write), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready after reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        expHits = 0; expMisses = 0;
        foreach (vecs[i]) begin
            doReq(vecs[i].wr, vecs[i].addr, vecs[i].wdata, h, d, rc, wc, ok, dn);
            check($sformatf("vec%0d done", i), 32'(dn), 32'd1);
            check($sformatf("vec%0d hit", i), 32'(h), 32'(vecs[i].expHit));
            check($sformatf("vec%0d rdata", i), d, vecs[i].expData);
            check($sformatf("vec%0d read cycles", i), 32'(rc),
                  (!vecs[i].wr && !vecs[i].expHit) ? 32'(MEM_LAT) : 32'd0);
            check($sformatf("vec%0d write cycles", i), 32'(wc), vecs[i].wr ? 32'd1 : 32'd0);
            check($sformatf("vec%0d memory bus", i), 32'(ok), 32'd1);
            if (!vecs[i].wr) begin
                if (vecs[i].expHit) expHits++; else expMisses++;
            end
        end

        // Back-to-back hits on the cached 0x1004 line: one request per cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1004;
        @(posedge clk); @(negedge clk);
        check("b2b0 valid", 32'(resp_valid), 32'd1);
        check("b2b0 rdata", resp_rdata, 32'd20);
        check("b2b0 ready", 32'(req_ready), 32'd1);
        req_addr = 15'h1007;
        @(posedge clk); @(negedge clk);
        check("b2b1 valid", 32'(resp_valid), 32'd1);
        check("b2b1 rdata", resp_rdata, 32'd23);
        req_addr = 15'h1006;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("b2b2 valid", 32'(resp_valid), 32'd1);
        check("b2b2 hit", 32'(resp_hit), 32'd1);
        check("b2b2 rdata", resp_rdata, 32'h1234);
        check("b2b mem_read", 32'(mem_read), 32'd0);
        expHits += 3;
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'(expHits));
        check("miss_count", miss_count, 32'(expMisses));
`endif
        @(negedge clk);
        check("idle after b2b", 32'(resp_valid), 32'd0);

        // Reset in the second FILL cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0200;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("fill cycle1 mem_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset mid-fill mem_read", 32'(mem_read), 32'd0);
        check("reset mid-fill req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        check("mid-fill reset resp_valid", 32'(resp_valid), 32'd0);
`ifdef CACHE_STATS_EN
        check("hit_count cleared", hit_count, 32'd0);
        check("miss_count cleared", miss_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        doReq(1'b0, 15'h0200, 32'h0, h, d, rc, wc, ok, dn);
        check("refill done", 32'(dn), 32'd1);
        check("refill hit", 32'(h), 32'd0);
        check("refill rdata", d, 32'h1000_0200);
        check("refill read cycles", 32'(rc), 32'(MEM_LAT));
        doReq(1'b0, 15'h0005, 32'h0, h, d, rc, wc, ok, dn);
        check("post-reset 0x0005 hit", 32'(h), 32'd0);
        check("post-reset 0x0005 rdata", d, 32'hDEAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped read/write cache controller sitting between the CPU load/store stage and the word-addressed data memory.
- On a read miss it fetches a 4-word block through the memory's four block read ports in one access and fills the line.
- Writes are write-through, no-write-allocate.
- Provides hit/miss indication per request for performance measurement.

Parameters:
- WORD, 32, data word width in bits
- ADDRESSL, 15, word-address width (matches data memory)
- LINES, 1024, number of cache lines (power of 2); INDEXL = log2(LINES)
- MEM_LATENCY, 1, cycles mem_read is held before block data is sampled (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDRESSL  word address
- req_wdata  in  WORD  store data
- req_ready  out  1  controller can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  WORD  load data (valid with resp_valid on loads, 0 otherwise)
- resp_hit  out  1  request hit in cache (valid with resp_valid)
- mem_address  out  ADDRESSL  single-word address (writes)
- mem_address0..mem_address3  out  ADDRESSL each  block word addresses {tag,index,2'bNN}
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_write_data  out  WORD  store data to memory
- mem_block0..mem_block3  in  WORD each  block words from memory (high-Z when mem_read=0)

Behaviour:
- Address split: offset = addr[1:0], index = addr[INDEXL+1:2], tag = addr[ADDRESSL-1:INDEXL+2] (3 bits at defaults).
- Storage per line: valid bit, tag, 4 words. Lookup is combinational on req_addr; hit = valid && tag match.
- Reset (async, rst_n=0): all valid bits 0; state IDLE; req_ready=0 during reset, 1 in the first cycle after release; all other outputs 0. Data/tag contents are don't-care.
- IDLE: req_ready=1. A request is accepted on a rising edge where req_valid && req_ready.
- IDLE, read hit: stay IDLE. Next cycle: resp_valid=1, resp_hit=1, resp_rdata = cached word. Back-to-back hits sustain 1 request/cycle.
- IDLE, read miss: latch address, go to FILL.
- FILL:
  - req_ready=0, mem_read=1, mem_address0..3 driven from the latched line.
  - Cycle counter runs 0..MEM_LATENCY-1. On the edge ending the last cycle, sample mem_block0..3, write the line (valid=1, tag), go to IDLE.
  - Next cycle: resp_valid=1, resp_hit=0, resp_rdata = word at the latched offset, taken from the sampled block rather than re-read.
- IDLE, write: latch addr/data, go to WRITE; hit status is evaluated at accept.
- WRITE:
  - Exactly one cycle: req_ready=0, mem_write=1, mem_address = latched addr, mem_write_data = latched data.
  - If the write hit, the cached word is updated on the same edge; valid and tag are unchanged. A miss does not allocate.
  - Go to IDLE. Next cycle: resp_valid=1, resp_hit = hit status, resp_rdata=0.
- mem_read and mem_write are never both 1. mem_block inputs are ignored outside the FILL sampling edge, because Z/X must not enter the array.
- No response backpressure: the consumer must take resp_valid when it pulses.
- Read immediately after a write to the same address: the read returns the written data (hit path updated; miss path fills from memory, which already holds it).
- Reset mid-FILL or mid-WRITE: abandon immediately; no line is written; memory enables drop asynchronously to 0.

Optional Feature:
- Macro: CACHE_STATS_EN.
- With the macro: outputs hit_count and miss_count, 32 bits each. They count completed loads only, increment on resp_valid, saturate at all-ones, and clear on reset.
- Without the macro: these ports and counters are absent.

Decomposition:
- Package cache_pkg holds:
  - WORD, ADDRESSL and LINES defaults
  - derived INDEXL and TAGL
  - state encoding: IDLE, FILL, WRITE
  - field-extract functions for tag, index and offset
- One sub-module, cache_line_array: valid/tag/data storage with combinational lookup, a full-line fill port, and a single-word write port. Valid clears on rst_n.

Test Plan:
- Cold read: after reset, load addr 0x0005 with memory[0x0004..0x0007]=10,11,12,13 -> mem_read held MEM_LATENCY cycles with addresses 0x0004..0x0007; resp_rdata=11, resp_hit=0.
- Warm read: load 0x0006 after the above -> resp one cycle after accept, rdata=12, hit=1, mem_read stays 0.
- Conflict: load 0x1005 (same index, tag 1) then load 0x0005 -> both miss; second refetch returns 11.
- Write hit: store 0xDEAD to 0x0005 (line cached) -> one mem_write cycle at 0x0005 with data 0xDEAD, resp_hit=1; then load 0x0005 -> hit, rdata 0xDEAD.
- Write miss: store 0xBEEF to 0x0100 (not cached) -> mem_write once, resp_hit=0; then load 0x0100 -> miss, rdata 0xBEEF.
- Reset during FILL (MEM_LATENCY=3, rst_n low in cycle 2) -> mem_read=0 immediately; a later load of the same address misses. With CACHE_STATS_EN, both counters read 0 after reset.
